// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states, byte-enable patterns.
package mips_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // Size 2'b11 is an alias for a word access.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Pipeline-side request/response and data-memory handshake bundle for mips_lsu.
interface mips_lsu_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              stall;
   logic              resp_valid;
   logic [31:0]       load_data;
   logic              misaligned;
   logic              bus_err;
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport master (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output stall, resp_valid, load_data, misaligned, bus_err,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  stall, resp_valid, load_data, misaligned, bus_err,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load lane select/extension, misalign flag.
module lsu_align
   import mips_lsu_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata_i[8*gi +: 8];
   end

   assign byte_sel = lane[addr_lo_i];
   assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      be_o         = BE_WORD;
      wdata_o      = wdata_i;
      rdata_o      = rdata_i;
      misaligned_o = 1'b0;
      if (is_word(size_i)) begin
         misaligned_o = |addr_lo_i;
      end else if (size_i == SZ_HALF) begin
         be_o         = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
         wdata_o      = {2{wdata_i[15:0]}};
         rdata_o      = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
         misaligned_o = addr_lo_i[0];
      end else begin
         be_o         = BE_BYTE0 << addr_lo_i;
         wdata_o      = {4{wdata_i[7:0]}};
         rdata_o      = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      end
   end

endmodule

// File: rtl/mips_lsu.sv
// MEM-stage load/store initiator driving a req/ack word memory.
// Optional ack watchdog enabled by defining MIPS_LSU_TIMEOUT_EN.
module mips_lsu
   import mips_lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic       clk,
   input logic       rst,
   mips_lsu_if.master bus
);

   logic [1:0]        state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              mis_q, mis_d;
   logic              berr_q, berr_d;

   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_mis;
   logic        timeout;

   // req_* are held stable until resp_valid, so the live request also drives the load lane select.
   lsu_align u_align (
      .addr_lo_i    (bus.req_addr[1:0]),
      .size_i       (bus.req_size),
      .unsigned_i   (bus.req_unsigned),
      .wdata_i      (bus.req_wdata),
      .rdata_i      (bus.mem_rdata),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .rdata_o      (al_rdata),
      .misaligned_o (al_mis)
   );

`ifdef MIPS_LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      cnt_q <= '0;
      else if (state_q != ST_ISSUE) cnt_q <= '0;
      else                          cnt_q <= cnt_q + 1'b1;
   end

   assign timeout = (state_q == ST_ISSUE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout            = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      mis_d       = mis_q;
      berr_d      = berr_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               load_data_d = '0;
               if (al_mis) begin
                  mis_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  mem_we_d    = bus.req_write;
                  mem_be_d    = al_be;
                  mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = al_wdata;
                  state_d     = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            // An ack in the watchdog expiry cycle still completes normally.
            if (bus.mem_ack) begin
               mem_we_d    = 1'b0;
               load_data_d = bus.req_write ? 32'h0 : al_rdata;
               state_d     = ST_DONE;
            end else if (timeout) begin
               mem_we_d    = 1'b0;
               load_data_d = '0;
               berr_d      = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            mis_d   = 1'b0;
            berr_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         load_data_q <= '0;
         mis_q       <= 1'b0;
         berr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
         mis_q       <= mis_d;
         berr_q      <= berr_d;
      end
   end

   assign bus.resp_valid = (state_q == ST_DONE);
   assign bus.stall      = bus.req_valid & ~bus.resp_valid;
   assign bus.mem_req    = (state_q == ST_ISSUE);
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.load_data  = load_data_q;
   assign bus.misaligned = mis_q;
   assign bus.bus_err    = berr_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed, table-driven bench for mips_lsu; timeout vectors run only when MIPS_LSU_TIMEOUT_EN is defined.
module tb_mips_lsu;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mips_lsu_if #(.ADDR_W(32)) bus ();

   mips_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          write;
      bit [1:0]    size;
      bit          uns;
      bit [31:0]   addr;
      bit [31:0]   wdata;
      bit [31:0]   rdata;
      int          ack_delay;   // -1: never ack
      bit          exp_mis;
      bit          exp_berr;
      bit          exp_we;
      bit [3:0]    exp_be;
      bit [31:0]   exp_wdata;
      bit [31:0]   exp_load;
      int          exp_req_cyc;
      int          exp_lat;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input bit wr, input bit [1:0] sz, input bit uns,
                               input bit [31:0] addr, input bit [31:0] wd, input bit [31:0] rd,
                               input int dly, input bit mis, input bit berr, input bit [3:0] be,
                               input bit [31:0] exp_wd, input bit [31:0] exp_ld);
      vec_t v;
      v.name = name; v.write = wr; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
      v.rdata = rd; v.ack_delay = dly; v.exp_mis = mis; v.exp_berr = berr; v.exp_we = wr;
      v.exp_be = be; v.exp_wdata = exp_wd; v.exp_load = exp_ld;
      v.exp_req_cyc = mis ? 0 : ((dly < 0) ? TO : dly + 1);
      v.exp_lat     = v.exp_req_cyc + 1;
      return v;
   endfunction

   // Called just after a negedge with the LSU idle; returns just after the cycle following resp_valid.
   task automatic run_vec(input vec_t v);
      int  req_cyc;
      bit  done;
      bit  seen;
      bus.req_valid    = 1'b1;
      bus.req_write    = v.write;
      bus.req_size     = v.size;
      bus.req_unsigned = v.uns;
      bus.req_addr     = v.addr;
      bus.req_wdata    = v.wdata;
      bus.mem_rdata    = v.rdata;
      bus.mem_ack      = 1'b0;
      #1;
      chk({v.name, " stall_pending"}, 32'(bus.stall), 32'd1);
      req_cyc = 0; done = 1'b0; seen = 1'b0;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            done = 1'b1;
            chk({v.name, " req_cycles"}, 32'(req_cyc), 32'(v.exp_req_cyc));
            chk({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
            chk({v.name, " load_data"}, bus.load_data, v.exp_load);
            chk({v.name, " misaligned"}, 32'(bus.misaligned), 32'(v.exp_mis));
            chk({v.name, " bus_err"}, 32'(bus.bus_err), 32'(v.exp_berr));
            chk({v.name, " stall_resp"}, 32'(bus.stall), 32'd0);
            chk({v.name, " mem_req_resp"}, 32'(bus.mem_req), 32'd0);
         end else if (bus.mem_req) begin
            req_cyc++;
            if (!seen) begin
               seen = 1'b1;
               chk({v.name, " mem_we"}, 32'(bus.mem_we), 32'(v.exp_we));
               chk({v.name, " mem_be"}, 32'(bus.mem_be), 32'(v.exp_be));
               chk({v.name, " mem_addr"}, bus.mem_addr, v.addr & 32'hFFFF_FFFC);
               chk({v.name, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
            end
            bus.mem_ack = (v.ack_delay >= 0) && (req_cyc == v.ack_delay + 1);
         end else begin
            bus.mem_ack = 1'b0;
         end
      end
      if (!done) chk({v.name, " resp_timeout"}, 32'd0, 32'd1);
      bus.mem_ack   = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk({v.name, " resp_pulse"}, 32'(bus.resp_valid), 32'd0);
      $display("txn %-10s addr=0x%08h we=%0d load=0x%08h mis=%0d berr=%0d", v.name, v.addr,
               v.write, v.exp_load, v.exp_mis, v.exp_berr);
   endtask

   initial begin
      vec_t v;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

      //         name        wr sz     u  addr          wdata         rdata         dly mis be  be       exp_wdata     exp_load
      vq.push_back(mk("lw_100",  0, 2'b10, 0, 32'h100, 32'h1122_3344, 32'hDEAD_BEEF, 3, 0, 0, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF));
      vq.push_back(mk("lb_103",  0, 2'b00, 0, 32'h103, 32'h0,         32'h80FF_FF7F, 0, 0, 0, 4'b1000, 32'h0,         32'hFFFF_FF80));
      vq.push_back(mk("lbu_103", 0, 2'b00, 1, 32'h103, 32'h0,         32'h80FF_FF7F, 1, 0, 0, 4'b1000, 32'h0,         32'h0000_0080));
      vq.push_back(mk("sh_202",  1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0));
      vq.push_back(mk("lw_101",  0, 2'b10, 0, 32'h101, 32'h0,         32'h5555_5555, 0, 1, 0, 4'b0000, 32'h0,         32'h0));
      vq.push_back(mk("lh_103",  0, 2'b01, 0, 32'h103, 32'h0,         32'h5555_5555, 0, 1, 0, 4'b0000, 32'h0,         32'h0));
      vq.push_back(mk("lh_102",  0, 2'b01, 0, 32'h102, 32'h0,         32'h8001_7FFF, 2, 0, 0, 4'b1100, 32'h0,         32'hFFFF_8001));
      vq.push_back(mk("lhu_100", 0, 2'b01, 1, 32'h100, 32'h0,         32'h1234_F00D, 0, 0, 0, 4'b0011, 32'h0,         32'h0000_F00D));
      vq.push_back(mk("sb_101",  1, 2'b00, 0, 32'h101, 32'hFFFF_FF5A, 32'h0,         1, 0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h0));
      vq.push_back(mk("sw_3fc",  1, 2'b10, 0, 32'h3FC, 32'hCAFE_F00D, 32'h0,         0, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0));
      vq.push_back(mk("lb_100",  0, 2'b00, 0, 32'h100, 32'h0,         32'h0000_007F, 0, 0, 0, 4'b0001, 32'h0,         32'h0000_007F));
      vq.push_back(mk("lw_sz11", 0, 2'b11, 0, 32'h010, 32'h0,         32'h0BAD_F00D, 0, 0, 0, 4'b1111, 32'h0,         32'h0BAD_F00D));
      vq.push_back(mk("lhu_001", 0, 2'b01, 1, 32'h001, 32'h0,         32'hFFFF_FFFF, 0, 1, 0, 4'b0000, 32'h0,         32'h0));
`ifdef MIPS_LSU_TIMEOUT_EN
      vq.push_back(mk("lw_to",   0, 2'b10, 0, 32'h400, 32'h0,         32'h1357_9BDF, -1, 0, 1, 4'b1111, 32'h0,        32'h0));
      vq.push_back(mk("lw_ack4", 0, 2'b10, 0, 32'h404, 32'h0,         32'h1357_9BDF, TO-1, 0, 0, 4'b1111, 32'h0,      32'h1357_9BDF));
`endif

      #1;
      chk("rst mem_req",    32'(bus.mem_req), 32'd0);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst load_data",  bus.load_data, 32'd0);
      chk("rst mem_be",     32'(bus.mem_be), 32'd0);
      chk("rst mem_addr",   bus.mem_addr, 32'd0);
      chk("rst flags",      {30'd0, bus.misaligned, bus.bus_err}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // A stray ack while idle must not complete anything.
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("idle_ack resp_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);

      for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

      // Reset asserted mid-wait: mem_req must drop at once and no response may follow.
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h100; bus.mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstmid mem_req_before", 32'(bus.mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid mem_req_after", 32'(bus.mem_req), 32'd0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rstmid no_resp", 32'(bus.resp_valid), 32'd0);
      end
      $display("txn rst_mid   reset during wait handled");
      v = mk("lw_after", 0, 2'b10, 0, 32'h100, 32'h0, 32'hA5A5_0F0F, 1, 0, 0, 4'b1111, 32'h0, 32'hA5A5_0F0F);
      run_vec(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
